// File: rtl/caravel_clock_gen_pkg.sv
// Shared constants and channel state type for the multi-channel PLL clock generator.
package caravel_clock_pkg;

    localparam int SIZE_DEFAULT = 8;
    localparam int DIV_STOP     = 0;
    localparam int DIV_MIN      = 2;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } chan_state_e;

endpackage

// File: rtl/caravel_clock_gen_if.sv
// Programming and clock-output bundle between housekeeping and caravel_clock_gen.
interface caravel_clock_gen_if
    import caravel_clock_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int SIZE = SIZE_DEFAULT
);

    logic [NCH*SIZE-1:0] div_N;
    logic [NCH-1:0]      div_load;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      tick;
    logic [NCH-1:0]      pending;
    logic [NCH-1:0]      rst_out;

    modport master (
        output div_N, div_load,
        input  clk_out, tick, pending, rst_out
    );

    modport slave (
        input  div_N, div_load,
        output clk_out, tick, pending, rst_out
    );

endinterface

// File: rtl/caravel_clock_gen_channel.sv
// One divided-clock channel: period counter, pending divisor, staged domain reset.
// CARAVEL_CLOCK_GEN_ODD_DUTY_EN adds a negedge high-phase copy for 50% duty at odd N.
module clock_gen_channel
    import caravel_clock_pkg::*;
#(
    parameter int SIZE        = SIZE_DEFAULT,
    parameter int RST_PERIODS = 3
) (
    input  logic            pll_clk,
    input  logic            reset,
    input  logic [SIZE-1:0] div_n,
    input  logic            div_load,
    output logic            clk_out,
    output logic            tick,
    output logic            pending,
    output logic            rst_out
);

    localparam int RW = $clog2(RST_PERIODS + 2);

    chan_state_e     state;
    logic [SIZE-1:0] div_act;
    logic [SIZE-1:0] div_pend;
    logic [SIZE-1:0] cnt;
    logic [RW-1:0]   rst_cnt;
    logic            clk_q;
    logic            tick_q;
    logic            pend_q;
    logic            rst_q;

    logic [SIZE-1:0] div_new;
    logic [SIZE-1:0] half_act;
    logic            wrap;
    logic            apply;

    function automatic logic [SIZE-1:0] eff_div(input logic [SIZE-1:0] d);
        if (d == SIZE'(1)) return SIZE'(DIV_MIN);
        return d;
    endfunction

    assign div_new  = eff_div(div_pend);
    assign half_act = div_act >> 1;
    assign wrap     = (state == RUNNING) && (cnt == div_act - SIZE'(1));
    // A stopped channel applies at once; a running one only at its period boundary.
    assign apply    = pend_q && ((state == STOPPED) || wrap);

    always_ff @(posedge pll_clk) begin
        if (reset) begin
            state    <= STOPPED;
            div_act  <= '0;
            div_pend <= '0;
            pend_q   <= 1'b0;
            cnt      <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            rst_q    <= 1'b1;
            rst_cnt  <= '0;
        end else begin
            // A load coinciding with an apply stays queued for the next boundary.
            if (div_load) begin
                div_pend <= div_n;
                pend_q   <= 1'b1;
            end else if (apply) begin
                pend_q   <= 1'b0;
            end

            if (apply && (div_new == SIZE'(DIV_STOP))) begin
                state   <= STOPPED;
                div_act <= '0;
                cnt     <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                rst_q   <= 1'b1;
            end else if (state == STOPPED) begin
                if (apply) begin
                    state   <= RUNNING;
                    div_act <= div_new;
                    cnt     <= '0;
                    clk_q   <= 1'b1;
                    tick_q  <= 1'b1;
                    rst_q   <= (RST_PERIODS != 0);
                    rst_cnt <= RW'(1);
                end
            end else if (wrap) begin
                cnt    <= '0;
                clk_q  <= 1'b1;
                tick_q <= 1'b1;
                if (apply) div_act <= div_new;
                if (rst_q) begin
                    if (rst_cnt == RW'(RST_PERIODS)) rst_q <= 1'b0;
                    else rst_cnt <= rst_cnt + RW'(1);
                end
            end else begin
                cnt    <= cnt + SIZE'(1);
                clk_q  <= (cnt + SIZE'(1)) < half_act;
                tick_q <= 1'b0;
            end
        end
    end

`ifdef CARAVEL_CLOCK_GEN_ODD_DUTY_EN
    logic clk_n;

    // Half-cycle-late copy stretches the high phase by half a cycle for odd divisors.
    always_ff @(negedge pll_clk) begin
        if (reset) clk_n <= 1'b0;
        else       clk_n <= clk_q;
    end

    assign clk_out = clk_q | (clk_n & div_act[0]);
`else
    assign clk_out = clk_q;
`endif

    assign tick    = tick_q;
    assign pending = pend_q;
    assign rst_out = rst_q;

endmodule

// File: rtl/caravel_clock_gen.sv
// NCH-channel glitch-free clock divider running from pll_clk, one clock_gen_channel per output.
// Optional odd-divisor 50% duty via CARAVEL_CLOCK_GEN_ODD_DUTY_EN.
module caravel_clock_gen
    import caravel_clock_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int SIZE        = SIZE_DEFAULT,
    parameter int RST_PERIODS = 3
) (
    input  logic               pll_clk,
    input  logic               reset,
    caravel_clock_gen_if.slave bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clock_gen_channel #(
            .SIZE        (SIZE),
            .RST_PERIODS (RST_PERIODS)
        ) u_ch (
            .pll_clk  (pll_clk),
            .reset    (reset),
            .div_n    (bus.div_N[i*SIZE +: SIZE]),
            .div_load (bus.div_load[i]),
            .clk_out  (bus.clk_out[i]),
            .tick     (bus.tick[i]),
            .pending  (bus.pending[i]),
            .rst_out  (bus.rst_out[i])
        );
    end

endmodule

// File: tb/tb_caravel_clock_gen.sv
// Self-checking bench for caravel_clock_gen: cycle-stamped expectations queued at stimulus time.
module tb_caravel_clock_gen;
    import caravel_clock_pkg::*;

    localparam int NCH  = 2;
    localparam int SIZE = 8;
    localparam int RSTP = 3;

    logic pll_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    caravel_clock_gen_if #(.NCH(NCH), .SIZE(SIZE)) bus ();

    caravel_clock_gen #(.NCH(NCH), .SIZE(SIZE), .RST_PERIODS(RSTP)) dut (
        .pll_clk (pll_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 pll_clk = ~pll_clk;
    always @(posedge pll_clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    ch;
        int    fld;
        logic  val;
        string name;
    } exp_t;

    typedef struct {
        int ch;
        int n;
        int neff;
    } vec_t;

    exp_t sb[$];

    function automatic logic observe(input int ch, input int fld);
        case (fld)
            0:       return bus.clk_out[ch];
            1:       return bus.tick[ch];
            2:       return bus.pending[ch];
            default: return bus.rst_out[ch];
        endcase
    endfunction

    // Outputs are stable at the falling edge; every expectation due by now is compared.
    always @(negedge pll_clk) begin : mon
        exp_t e;
        logic a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = observe(e.ch, e.fld);
            checks++;
            if (e.cyc != cyc || a !== e.val) begin
                errors++;
                $display("FAIL %s ch%0d cycle %0d: got %b, expected %b (due cycle %0d)",
                         e.name, e.ch, cyc, a, e.val, e.cyc);
            end
        end
    end

    task automatic push(input int c, input int ch, input int fld, input logic v, input string nm);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.ch   = ch;
        e.fld  = fld;
        e.val  = v;
        e.name = nm;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic exp_all(input int c, input int ch, input logic clk, input logic tk,
                           input logic pd, input logic rs);
        push(c, ch, 0, clk, "clk_out");
        push(c, ch, 1, tk,  "tick");
        push(c, ch, 2, pd,  "pending");
        push(c, ch, 3, rs,  "rst_out");
    endtask

    // Expected waveform: floor(n/2) cycles high then low, tick on the first cycle of each period.
    task automatic exp_wave(input int t0, input int ch, input int n, input int periods,
                            input bit do_clk);
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < n; k++) begin
                if (do_clk) push(t0 + p*n + k, ch, 0, (k < n/2), "clk_out");
                push(t0 + p*n + k, ch, 1, (k == 0), "tick");
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pll_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 3000) begin
            step(1);
            guard++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    task automatic do_reset(output int c);
        reset        = 1'b1;
        bus.div_load = '0;
        bus.div_N    = '0;
        step(2);
        reset = 1'b0;
        c = cyc;
        for (int ch = 0; ch < NCH; ch++) exp_all(c, ch, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_ch(input int ch, input int n, output int t);
        bus.div_N[ch*SIZE +: SIZE] = SIZE'(n);
        bus.div_load[ch]           = 1'b1;
        t = cyc;
        step(1);
        bus.div_load[ch] = 1'b0;
    endtask

    initial begin : stim
        vec_t vecs[7];
        int   c;
        int   t;
        int   s;
        int   u;

        bus.div_N    = '0;
        bus.div_load = '0;

        vecs = '{'{0, 4, 4}, '{1, 3, 3}, '{0, 1, 2}, '{1, 0, 0},
                 '{0, 2, 2}, '{1, 7, 7}, '{0, 255, 255}};

        // Reset then idle: everything stopped and held in reset.
        do_reset(c);
        for (int k = 1; k <= 20; k++)
            for (int ch = 0; ch < NCH; ch++) exp_all(c + k, ch, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Start a stopped channel with each divisor in the table.
        for (int i = 0; i < 7; i++) begin
            do_reset(c);
            step(1);
            load_ch(vecs[i].ch, vecs[i].n, t);
            push(t + 1, vecs[i].ch, 2, 1'b1, "pending");
            push(t + 1, vecs[i].ch, 0, 1'b0, "clk_out");
            push(t + 1, vecs[i].ch, 3, 1'b1, "rst_out");
            if (vecs[i].neff == 0) begin
                for (int k = 2; k <= 10; k++)
                    exp_all(t + k, vecs[i].ch, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                s = t + 2;
                push(s, vecs[i].ch, 2, 1'b0, "pending");
                exp_wave(s, vecs[i].ch, vecs[i].neff, 4, 1'b1);
                push(s + RSTP*vecs[i].neff - 1, vecs[i].ch, 3, 1'b1, "rst_out");
                push(s + RSTP*vecs[i].neff,     vecs[i].ch, 3, 1'b0, "rst_out");
                push(s + 4*vecs[i].neff - 1,    vecs[i].ch, 3, 1'b0, "rst_out");
            end
            exp_all(t + 5, 1 - vecs[i].ch, 1'b0, 1'b0, 1'b0, 1'b1);
            drain();
        end

        // Running N=4, load N=6 at cnt==1: old period completes, rst_out untouched.
        do_reset(c);
        step(1);
        load_ch(0, 4, t);
        s = t + 2;
        exp_wave(s, 0, 4, 5, 1'b1);
        push(s + 11, 0, 3, 1'b1, "rst_out");
        push(s + 12, 0, 3, 1'b0, "rst_out");
        wait_until(s + 17);
        load_ch(0, 6, t);
        push(s + 18, 0, 2, 1'b1, "pending");
        push(s + 19, 0, 2, 1'b1, "pending");
        push(s + 20, 0, 2, 1'b0, "pending");
        exp_wave(s + 20, 0, 6, 2, 1'b1);
        push(s + 20, 0, 3, 1'b0, "rst_out");
        push(s + 26, 0, 3, 1'b0, "rst_out");
        push(s + 31, 0, 3, 1'b0, "rst_out");
        drain();

        // Odd divisor duty.
        do_reset(c);
        step(1);
        load_ch(0, 5, t);
        s = t + 2;
        push(s, 0, 2, 1'b0, "pending");
`ifdef CARAVEL_CLOCK_GEN_ODD_DUTY_EN
        exp_wave(s, 0, 5, 3, 1'b0);
`else
        exp_wave(s, 0, 5, 3, 1'b1);
`endif
        drain();

        // Stop ch0 at its boundary while ch1 starts with N=3 from the same load cycle.
        do_reset(c);
        step(1);
        load_ch(0, 4, t);
        s = t + 2;
        exp_wave(s, 0, 4, 5, 1'b1);
        wait_until(s + 17);
        bus.div_N[0 +: SIZE]    = SIZE'(0);
        bus.div_N[SIZE +: SIZE] = SIZE'(3);
        bus.div_load            = 2'b11;
        u = cyc;
        step(1);
        bus.div_load = '0;
        push(u + 1, 0, 2, 1'b1, "pending");
        push(u + 2, 0, 2, 1'b1, "pending");
        push(u + 2, 0, 3, 1'b0, "rst_out");
        exp_all(u + 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_all(u + 8, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(u + 1, 1, 2, 1'b1, "pending");
        push(u + 2, 1, 2, 1'b0, "pending");
        push(u + 2, 1, 3, 1'b1, "rst_out");
        exp_wave(u + 2, 1, 3, 3, 1'b1);
        drain();

        // Reset in the same cycle as loads mid-period: reset wins, loads discarded.
        do_reset(c);
        step(1);
        load_ch(0, 4, t);
        s = t + 2;
        exp_wave(s, 0, 4, 1, 1'b1);
        wait_until(s + 5);
        reset                   = 1'b1;
        bus.div_N[0 +: SIZE]    = SIZE'(6);
        bus.div_N[SIZE +: SIZE] = SIZE'(7);
        bus.div_load            = 2'b11;
        step(1);
        reset        = 1'b0;
        bus.div_load = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_all(s + 6,  ch, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_all(s + 7,  ch, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_all(s + 12, ch, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
